// File: rtl/mem_ctrl.sv
// Single-port 16-bit SRAM controller with active-low OE/WE handshake and programmable read wait states.
// Optional power-on clearing sweep is enabled by defining MEM_CTRL_INIT_EN.
module mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Data_to_SRAM,
    output logic [15:0] Data_from_SRAM,
    output logic        Ready,
    output logic        Init_Done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DONE,
        S_WR_DONE,
        S_INIT
    } state_t;

`ifdef MEM_CTRL_INIT_EN
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    logic [15:0]       mem [DEPTH];
    logic [15:0]       mem_q;

    state_t            state_reg, state_next;
    logic [2:0]        wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic [15:0]       rd_data_reg;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic              rd_load;

`ifdef MEM_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_ptr_reg, init_ptr_next;
`endif

    // Upper address bits alias by design; fold them so they are visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= RESET_STATE;
            wait_cnt_reg <= '0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
`ifdef MEM_CTRL_INIT_EN
            init_ptr_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_addr_reg  <= rd_addr_next;
            if (rd_load) begin
                rd_data_reg <= mem_q;
            end
`ifdef MEM_CTRL_INIT_EN
            init_ptr_reg <= init_ptr_next;
`endif
        end
    end

    // Storage: reading through rd_addr_next keeps mem_q one edge ahead of the load.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_q <= mem[rd_addr_next];
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        rd_addr_next  = rd_addr_reg;
`ifdef MEM_CTRL_INIT_EN
        init_ptr_next = init_ptr_reg;
`endif
        unique case (state_reg)
            S_IDLE: begin
                if (!WE) begin
                    state_next = S_WR_DONE;
                end else if (!OE) begin
                    state_next    = S_RD_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                    rd_addr_next  = ADDR[ADDR_W-1:0];
                end
            end
            S_RD_WAIT: begin
                if (wait_cnt_reg == 3'd0) begin
                    state_next = S_RD_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            S_RD_DONE: begin
                if (OE) begin
                    state_next = S_IDLE;
                end
            end
            S_WR_DONE: begin
                if (WE) begin
                    state_next = S_IDLE;
                end
            end
`ifdef MEM_CTRL_INIT_EN
            S_INIT: begin
                init_ptr_next = init_ptr_reg + 1'b1;
                if (init_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Writes are gated by Reset so an access interrupted by reset never lands.
    always_comb begin
        Ready     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ADDR[ADDR_W-1:0];
        mem_wdata = Data_to_SRAM;
        rd_load   = 1'b0;
        case (state_reg)
            S_IDLE:    mem_we  = Reset & ~WE;
            S_RD_WAIT: rd_load = (wait_cnt_reg == 3'd0);
            S_RD_DONE: Ready   = 1'b1;
            S_WR_DONE: Ready   = 1'b1;
`ifdef MEM_CTRL_INIT_EN
            S_INIT: begin
                mem_we    = Reset;
                mem_waddr = init_ptr_reg;
                mem_wdata = 16'h0000;
            end
`endif
            default: ;
        endcase
    end

    assign Data_from_SRAM = rd_data_reg;

`ifdef MEM_CTRL_INIT_EN
    assign Init_Done = (state_reg != S_INIT);
`else
    assign Init_Done = 1'b1;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table vectors, hand-written corner sequences and
// randomized traffic against an array-based model of the memory.
module tb_mem_ctrl;

`ifdef MEM_CTRL_INIT_EN
    localparam int AW        = 4;
    localparam int INIT_CYCS = 16;
`else
    localparam int AW        = 10;
    localparam int INIT_CYCS = 0;
`endif
    localparam int WS    = 1;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        oe;
    logic        we;
    logic [15:0] din;
    logic [15:0] dout;
    logic        ready;
    logic        init_done;

    mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .Clk           (clk),
        .Reset         (reset_n),
        .ADDR          (addr),
        .OE            (oe),
        .WE            (we),
        .Data_to_SRAM  (din),
        .Data_from_SRAM(dout),
        .Ready         (ready),
        .Init_Done     (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];
    int          written_q[$];
    logic [15:0] model_dout;

    typedef struct {
        bit          is_wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[9];

    function automatic int idx(input logic [15:0] a);
        return int'(a & 16'(DEPTH - 1));
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        model_mem[idx(a)] = d;
        if (!model_valid[idx(a)]) begin
            model_valid[idx(a)] = 1'b1;
            written_q.push_back(idx(a));
        end
    endtask

    task automatic model_clear_all();
        written_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 16'h0000;
            model_valid[i] = 1'b1;
            written_q.push_back(i);
        end
    endtask

    // Count rising edges after reset release until Init_Done is seen.
    task automatic wait_init(input int exp_cycles);
        int cycles;
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            check1("init_ready_low", ready, 1'b0);
        end
        we = 1'b1;
        checks++;
        if (cycles != exp_cycles) begin
            errors++;
            $display("FAIL init_cycles: got %0d expected %0d", cycles, exp_cycles);
        end
        $display("INIT done after %0d cycles", cycles);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_dout);
        @(negedge clk);
        addr = a; din = d; we = 1'b0; oe = 1'b1;
        @(posedge clk);
        #1;
        check1("wr_ready", ready, 1'b1);
        check16("wr_dout_hold", dout, exp_dout);
        @(negedge clk);
        we = 1'b1;
        @(posedge clk);
        #1;
        check1("wr_idle_ready", ready, 1'b0);
        $display("WR  addr=%h data=%h", a, d);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input logic [15:0] prev, input int hold);
        @(negedge clk);
        addr = a; we = 1'b1; oe = 1'b0;
        @(posedge clk);
        #1;
        check1("rd_capture_ready", ready, 1'b0);
        addr = 16'($urandom);
        we   = 1'($urandom);
        for (int k = 0; k < WS; k++) begin
            @(posedge clk);
            #1;
            check1("rd_wait_ready", ready, 1'b0);
            check16("rd_wait_dout", dout, prev);
        end
        @(posedge clk);
        #1;
        check1("rd_done_ready", ready, 1'b1);
        check16("rd_data", dout, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check1("rd_hold_ready", ready, 1'b1);
            check16("rd_hold_data", dout, exp);
        end
        @(negedge clk);
        oe = 1'b1; we = 1'b1;
        @(posedge clk);
        #1;
        check1("rd_idle_ready", ready, 1'b0);
        $display("RD  addr=%h data=%h", a, dout);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] e;

        vecs[0] = '{1'b1, 16'h0010, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0005, 16'hBEEF, 16'h1234};
        vecs[3] = '{1'b0, 16'h0405, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 16'h0001, 16'h1111, 16'hBEEF};
        vecs[5] = '{1'b1, 16'h0002, 16'h2222, 16'hBEEF};
        vecs[6] = '{1'b0, 16'h0001, 16'h0000, 16'h1111};
        vecs[7] = '{1'b1, 16'h0001, 16'h5A5A, 16'h1111};
        vecs[8] = '{1'b0, 16'h0001, 16'h0000, 16'h5A5A};

        for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
        model_dout = 16'h0000;

        reset_n = 1'b0; addr = 16'h0000; din = 16'h0000; oe = 1'b1; we = 1'b1;
        #1;
        check1("reset_ready", ready, 1'b0);
        check16("reset_dout", dout, 16'h0000);
        check1("reset_init_done", init_done, (INIT_CYCS == 0) ? 1'b1 : 1'b0);
        repeat (2) @(posedge clk);

`ifdef MEM_CTRL_INIT_EN
        // Write attempts during the sweep, plus a reset mid-sweep that must restart it.
        @(negedge clk);
        reset_n = 1'b1; we = 1'b0; din = 16'hFFFF; addr = 16'h0003;
        repeat (5) @(posedge clk);
        #1;
        check1("init_mid_done", init_done, 1'b0);
        reset_n = 1'b0;
        #1;
        check1("init_reset_done", init_done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; din = 16'hA5A5; addr = 16'h0007;
        wait_init(INIT_CYCS);
        model_clear_all();
        for (int i = 0; i < DEPTH; i++) begin
            do_read(16'(i), 16'h0000, model_dout, 0);
        end
`else
        @(negedge clk);
        reset_n = 1'b1;
        wait_init(INIT_CYCS);
`endif

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].a, vecs[i].d, vecs[i].exp);
                model_write(vecs[i].a, vecs[i].d);
            end else begin
                do_read(vecs[i].a, vecs[i].exp, model_dout, 0);
                model_dout = vecs[i].exp;
            end
        end

        // Simultaneous WE and OE: write wins, output register untouched.
        @(negedge clk);
        addr = 16'h0020; din = 16'h00AA; we = 1'b0; oe = 1'b0;
        @(posedge clk);
        #1;
        check1("both_ready", ready, 1'b1);
        check16("both_dout", dout, model_dout);
        @(negedge clk);
        we = 1'b1; oe = 1'b1;
        @(posedge clk);
        #1;
        check1("both_idle", ready, 1'b0);
        model_write(16'h0020, 16'h00AA);
        do_read(16'h0020, 16'h00AA, model_dout, 0);
        model_dout = 16'h00AA;

        // Address change during wait is ignored; OE held low keeps Ready asserted.
        do_write(16'h0001, 16'h1111, model_dout);
        model_write(16'h0001, 16'h1111);
        do_read(16'h0001, 16'h1111, model_dout, 10);
        model_dout = 16'h1111;

        // WE held low for several cycles writes exactly once with the first-edge data.
        do_write(16'h0031, 16'h3131, model_dout);
        model_write(16'h0031, 16'h3131);
        @(negedge clk);
        addr = 16'h0030; din = 16'h7777; we = 1'b0; oe = 1'b1;
        @(posedge clk);
        #1;
        addr = 16'h0031; din = 16'h8888;
        for (int h = 0; h < 4; h++) begin
            @(posedge clk);
            #1;
            check1("wr_hold_ready", ready, 1'b1);
        end
        @(negedge clk);
        we = 1'b1;
        @(posedge clk);
        model_write(16'h0030, 16'h7777);
        do_read(16'h0030, 16'h7777, model_dout, 0);
        model_dout = 16'h7777;
        do_read(16'h0031, 16'h3131, model_dout, 0);
        model_dout = 16'h3131;

        // Reset while in RD_WAIT clears outputs at once; WE low during reset must not write.
        @(negedge clk);
        addr = 16'h0031; oe = 1'b0; we = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check16("rst_rdwait_dout", dout, 16'h0000);
        check1("rst_rdwait_ready", ready, 1'b0);
        oe = 1'b1; we = 1'b0; addr = 16'h0030; din = 16'hDEAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        we = 1'b1;
        reset_n = 1'b1;
        model_dout = 16'h0000;
        wait_init(INIT_CYCS);
`ifdef MEM_CTRL_INIT_EN
        model_clear_all();
`endif
        do_read(16'h0030, model_mem[idx(16'h0030)], model_dout, 0);
        model_dout = model_mem[idx(16'h0030)];

        // Randomized traffic against the array model.
        for (int n = 0; n < 150; n++) begin
            if (($urandom_range(0, 1) == 0) || (written_q.size() == 0)) begin
                a = 16'($urandom);
                e = 16'($urandom);
                do_write(a, e, model_dout);
                model_write(a, e);
            end else begin
                a = 16'($urandom);
                a = (a & ~16'(DEPTH - 1)) | 16'(written_q[$urandom_range(0, written_q.size() - 1)]);
                e = model_mem[idx(a)];
                do_read(a, e, model_dout, $urandom_range(0, 2));
                model_dout = e;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
